div_iter: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the execute stage. Serves DIV and DIVU.

---
 rtl/div_iter.sv | 128 ++++++++++++
 tb/tb_div_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Result is {remainder, quotient}; div_ready pulses for exactly one cycle per completed divide.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [CW-1:0]      cnt_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic               last_step;

  always_comb begin
    op1_abs = (signed_div && opdata1[WIDTH-1]) ? ('0 - opdata1) : opdata1;
    op2_abs = (signed_div && opdata2[WIDTH-1]) ? ('0 - opdata2) : opdata2;

    // Remainder needs WIDTH+1 bits after the shift; bit WIDTH of the trial is the borrow.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end

    rem_fix   = neg_rem_q ? ('0 - rem_d) : rem_d;
    quo_fix   = neg_quo_q ? ('0 - quo_d) : quo_d;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      if (annul) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              rem_q <= '0;
              cnt_q <= '0;
              if (opdata2 == '0) begin
                // Dividend is parked in quo_q so DIVZERO can return it unchanged.
                quo_q   <= opdata1;
                state_q <= S_DIVZERO;
              end else begin
                quo_q     <= op1_abs;
                dvs_q     <= op2_abs;
                neg_quo_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                neg_rem_q <= signed_div & opdata1[WIDTH-1];
                state_q   <= S_ON;
              end
            end
          end
          S_DIVZERO: begin
            result_q <= {quo_q, {WIDTH{1'b1}}};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
          S_ON: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= 1'b1;
              state_q  <= S_END;
            end
          end
          S_END: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign div_ready = ready_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against a plain-arithmetic divide model.
module tb_div_iter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic [W-1:0] opdata1;
  logic [W-1:0] opdata2;
  logic         annul;
  logic         div_ready;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .div_ready  (div_ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide (start held in the current cycle), waits for the ready pulse,
  // checks latency/result, then returns in the IDLE cycle following END.
  task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b, input bit noise);
    int lat;
    logic [63:0] exp_r;
    exp_r      = ref_div(sd, a, b);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    lat = 1;
    while (!div_ready && lat < 100) begin
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    check("result", result, exp_r);
    tick();
    check("ready_pulse", {63'd0, div_ready}, 64'd0);
    check("result_hold", result, exp_r);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (div_ready) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit sd;

    rst        = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    repeat (3) tick();
    check("reset_ready", {63'd0, div_ready}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b1;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", result, {32'd2, 32'd14});
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("div_7_m2", result, {32'd1, 32'hFFFF_FFFD});
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", result, {32'h0, 32'h8000_0000});
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divu_big", result, {32'h8000_0000, 32'h0});
    do_div(1'b0, 32'd5, 32'd0, 1'b0);
    check("divu_zero", result, {32'd5, 32'hFFFF_FFFF});
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);

    // Annul at step 10 while start is also high; then a fresh divide.
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    annul = 1'b1;
    start = 1'b1;
    tick();
    annul = 1'b0;
    start = 1'b0;
    expect_quiet("annul_on", 40);
    do_div(1'b0, 32'd12345, 32'd67, 1'b0);

    // Annul together with start in IDLE: nothing accepted.
    opdata1 = 32'd9;
    opdata2 = 32'd4;
    start   = 1'b1;
    annul   = 1'b1;
    tick();
    start = 1'b0;
    annul = 1'b0;
    expect_quiet("annul_idle", 40);

    // Annul in DIVZERO.
    opdata2 = 32'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    annul = 1'b1;
    tick();
    annul = 1'b0;
    expect_quiet("annul_divzero", 5);
    check("annul_keeps_result", result, ref_div(1'b0, 32'd12345, 32'd67));

    // Random back-to-back divides, some with mid-divide start/operand noise.
    for (int n = 0; n < 40; n++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = sd ? 32'hFFFF_FFFF - $urandom_range(0, 15) : 32'(1) << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      do_div(sd, a, b, 1'($urandom_range(0, 1)));
    end

    // Reset at step 5 of a divide.
    signed_div = 1'b0;
    opdata1    = 32'd777;
    opdata2    = 32'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("rst_mid_ready", {63'd0, div_ready}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    rst = 1'b1;
    expect_quiet("rst_mid_quiet", 40);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
